// File: rtl/audio_pitch_shifter.sv
// audio_pitch_shifter: resamples a stream of multi-channel audio frames by
// repeating or skipping whole frames according to a Q.4 fixed-point step,
// applies a per-frame channel transform, and buffers results in a frame FIFO
// that drains toward the codec whenever it signals write readiness.
module audio_pitch_shifter #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned STEP_W     = 8
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [CHANNELS*DATA_W-1:0]     in_data,
  output logic                           in_read,
  input  logic [STEP_W-1:0]              step,
  input  logic [1:0]                     mode,
  input  logic                           out_ready,
  output logic                           out_write,
  output logic [CHANNELS*DATA_W-1:0]     out_data,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

  localparam int unsigned FW = CHANNELS * DATA_W;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = STEP_W - 3;

  localparam logic [DATA_W-1:0] S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] S_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e          state_q, state_d;

  logic [FW-1:0]   frame_q, frame_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      frac_q, frac_d;
  logic            rd_hold_q;

  logic [FW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q, level_d;

  logic            out_write_q;
  logic [FW-1:0]   out_data_q;

  logic [STEP_W:0] acc;
  logic [CW-1:0]   rep;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Per-channel transform selected by mode; applied once, at capture time.
  function automatic logic [FW-1:0] shape(input logic [FW-1:0] f,
                                          input logic [1:0]    m);
    logic [FW-1:0]     r;
    logic [DATA_W-1:0] s;
    r = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      s = f[c*DATA_W +: DATA_W];
      case (m)
        2'b00:   r[c*DATA_W +: DATA_W] = s;
        2'b01:   r[(CHANNELS-1-c)*DATA_W +: DATA_W] = s;
        2'b10:   r[c*DATA_W +: DATA_W] = '0;
        default: r[c*DATA_W +: DATA_W] = (s == S_MIN) ? S_MAX : (~s + 1'b1);
      endcase
    end
    return r;
  endfunction

  // Phase accumulator: integer part is the repeat count, fraction carries over.
  always_comb begin
    acc = {{(STEP_W-3){1'b0}}, frac_q} + {1'b0, step};
    rep = acc[STEP_W:4];
  end

  assign fifo_full  = (level_q == LW'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign pop        = !fifo_empty && out_ready;

  // FSM state register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: leave IDLE only when the captured frame must be emitted,
  // return once the final repeat has been pushed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_read && (rep != '0)) state_d = EMIT;
      EMIT: if (!fifo_full && (cnt_q == CW'(1))) state_d = IDLE;
    endcase
  end

  // FSM outputs: read strobe in IDLE (never back-to-back), push in EMIT.
  always_comb begin
    in_read = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: in_read = in_valid && (step != '0) && !rd_hold_q && !reset;
      EMIT: push    = !fifo_full;
    endcase
  end

  // Capture path next-state: frame, repeat count and fractional phase.
  always_comb begin
    frame_d = frame_q;
    cnt_d   = cnt_q;
    frac_d  = frac_q;
    if (in_read) begin
      frame_d = shape(in_data, mode);
      cnt_d   = rep;
      frac_d  = acc[3:0];
    end else if (push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Capture path registers; the hold flag also blocks a read in the first
  // cycle after reset so in_read is low on that cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      frame_q   <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      rd_hold_q <= 1'b1;
    end else begin
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      frac_q    <= frac_d;
      rd_hold_q <= in_read;
    end
  end

  // FIFO storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= frame_q;
    end
  end

  // Occupancy: push and pop in the same cycle cancel; full is judged on the
  // pre-pop level, so a pop from full frees space for the next cycle only.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO pointers and level; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Registered codec write side: strobe with head frame, data holds otherwise.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      out_write_q <= 1'b0;
      out_data_q  <= '0;
    end else if (pop) begin
      out_write_q <= 1'b1;
      out_data_q  <= mem_q[rd_ptr_q];
    end else begin
      out_write_q <= 1'b0;
    end
  end

  assign out_write  = out_write_q;
  assign out_data   = out_data_q;
  assign fifo_level = level_q;

endmodule
